// File: rtl/renee_pkg.sv
// Shared constants, state encoding and bumper record for the Renee navigation controller.
package renee_pkg;

    localparam logic [2:0] WA_F = 3'b100;
    localparam logic [2:0] WA_R = 3'b010;
    localparam logic [2:0] WA_S = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEEK   = 3'd1,
        ST_BACKUP = 3'd2,
        ST_TURN   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef struct packed {
        logic lb;
        logic rb;
        logic fb;
        logic bb;
    } bump_t;

    // A back-bumper hit cannot reverse further, so it escapes forward instead.
    function automatic logic [5:0] backup_action(input bump_t b);
        return b.bb ? {WA_F, WA_F} : {WA_R, WA_R};
    endfunction

    function automatic logic [5:0] turn_action(input bump_t b);
        if (b == 4'b0100)
            return {WA_R, WA_F};
        return {WA_F, WA_R};
    endfunction

endpackage

// File: rtl/renee_steer.sv
// Combinational beacon steering: lower sensor code means a stronger signal on that side.
module renee_steer
    import renee_pkg::*;
(
    input  logic [2:0] i_ls,
    input  logic [2:0] i_rs,
    output logic [2:0] o_lwa,
    output logic [2:0] o_rwa,
    output logic       o_strongest
);

    always_comb begin
        o_lwa = WA_S;
        o_rwa = WA_S;
        if (i_ls < i_rs) begin
            o_lwa = WA_S;
            o_rwa = WA_F;
        end else if (i_ls > i_rs) begin
            o_lwa = WA_F;
            o_rwa = WA_S;
        end else if (i_ls != 3'b111) begin
            o_lwa = WA_F;
            o_rwa = WA_F;
        end else begin
            o_lwa = WA_F;
            o_rwa = WA_R;
        end
    end

    assign o_strongest = (i_ls == 3'b000) && (i_rs == 3'b000);

endmodule

// File: rtl/renee_nav_ctrl.sv
// Top-level navigation sequencer: beacon seek, timed bump escape, debounced arrival, go/halt.
module renee_nav_ctrl
    import renee_pkg::*;
#(
    parameter int unsigned BACK_CYCLES   = 8,
    parameter int unsigned TURN_CYCLES   = 6,
    parameter int unsigned ARRIVE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic       halt,
    input  logic [2:0] ls,
    input  logic [2:0] rs,
    input  logic       lb,
    input  logic       rb,
    input  logic       fb,
    input  logic       bb,
    output logic [2:0] lwa,
    output logic [2:0] rwa,
    output logic [2:0] state,
    output logic       busy,
    output logic       arrived
);

    localparam logic [7:0] LP_BACK   = 8'(BACK_CYCLES - 1);
    localparam logic [7:0] LP_TURN   = 8'(TURN_CYCLES - 1);
    localparam logic [7:0] LP_ARRIVE = 8'(ARRIVE_CYCLES);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_lwa, r_rwa, w_lwa_nxt, w_rwa_nxt;
    logic [7:0] r_timer, w_timer_nxt;
    logic [7:0] r_arr_cnt, w_arr_nxt, w_arr_inc;
    bump_t      r_bump_q, w_bump_nxt, w_bump_in;
    logic       r_bb_prev;
    logic [2:0] w_steer_l, w_steer_r;
    logic       w_strongest, w_any_bump, w_bb_rise;

    renee_steer u_steer (
        .i_ls        (ls),
        .i_rs        (rs),
        .o_lwa       (w_steer_l),
        .o_rwa       (w_steer_r),
        .o_strongest (w_strongest)
    );

    assign w_bump_in  = {lb, rb, fb, bb};
    assign w_any_bump = lb | rb | fb | bb;
    assign w_bb_rise  = bb & ~r_bb_prev;
    assign w_arr_inc  = (r_arr_cnt >= LP_ARRIVE) ? LP_ARRIVE : r_arr_cnt + 8'd1;

    // Wheel actions are computed for the state being entered, so they register on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = (r_timer != 8'd0) ? r_timer - 8'd1 : 8'd0;
        w_arr_nxt   = r_arr_cnt;
        w_bump_nxt  = r_bump_q;
        w_lwa_nxt   = WA_S;
        w_rwa_nxt   = WA_S;
        if (halt) begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
            w_arr_nxt   = '0;
            w_bump_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (go) begin
                        w_state_nxt = ST_SEEK;
                        w_lwa_nxt   = w_steer_l;
                        w_rwa_nxt   = w_steer_r;
                    end
                end
                ST_SEEK: begin
                    if (w_any_bump) begin
                        w_state_nxt              = ST_BACKUP;
                        w_bump_nxt               = w_bump_in;
                        w_timer_nxt              = LP_BACK;
                        w_arr_nxt                = '0;
                        {w_lwa_nxt, w_rwa_nxt}   = backup_action(w_bump_in);
                    end else if (w_strongest && (w_arr_inc >= LP_ARRIVE)) begin
                        w_state_nxt = ST_DONE;
                        w_arr_nxt   = '0;
                    end else begin
                        w_arr_nxt = w_strongest ? w_arr_inc : 8'd0;
                        w_lwa_nxt = w_steer_l;
                        w_rwa_nxt = w_steer_r;
                    end
                end
                ST_BACKUP: begin
                    if ((r_timer == 8'd0) || (w_bb_rise && !r_bump_q.bb)) begin
                        w_state_nxt            = ST_TURN;
                        w_timer_nxt            = LP_TURN;
                        {w_lwa_nxt, w_rwa_nxt} = turn_action(r_bump_q);
                    end else begin
                        {w_lwa_nxt, w_rwa_nxt} = backup_action(r_bump_q);
                    end
                end
                ST_TURN: begin
                    if (r_timer == 8'd0) begin
                        w_state_nxt = ST_SEEK;
                        w_bump_nxt  = '0;
                        w_arr_nxt   = '0;
                        w_lwa_nxt   = w_steer_l;
                        w_rwa_nxt   = w_steer_r;
                    end else begin
                        {w_lwa_nxt, w_rwa_nxt} = turn_action(r_bump_q);
                    end
                end
                ST_DONE: begin
                    if (!go)
                        w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_lwa     <= WA_S;
            r_rwa     <= WA_S;
            r_timer   <= '0;
            r_arr_cnt <= '0;
            r_bump_q  <= '0;
            r_bb_prev <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lwa     <= w_lwa_nxt;
            r_rwa     <= w_rwa_nxt;
            r_timer   <= w_timer_nxt;
            r_arr_cnt <= w_arr_nxt;
            r_bump_q  <= w_bump_nxt;
            r_bb_prev <= bb;
        end
    end

    assign lwa     = r_lwa;
    assign rwa     = r_rwa;
    assign state   = r_state;
    assign busy    = (r_state == ST_SEEK) || (r_state == ST_BACKUP) || (r_state == ST_TURN);
    assign arrived = (r_state == ST_DONE);

endmodule

// File: tb/tb_renee_nav_ctrl.sv
// Scoreboard bench for renee_nav_ctrl: stimulus queues expectations, a monitor compares after each edge.
module tb_renee_nav_ctrl;
    import renee_pkg::*;

    localparam logic [2:0] F = WA_F;
    localparam logic [2:0] R = WA_R;
    localparam logic [2:0] S = WA_S;

    logic       clk = 1'b0;
    logic       rst_n, go, halt, lb, rb, fb, bb;
    logic [2:0] ls, rs;
    logic [2:0] lwa, rwa, state;
    logic       busy, arrived;

    typedef struct {
        int          cyc;
        string       name;
        logic [10:0] v;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_err = 0;

    renee_nav_ctrl #(.BACK_CYCLES(8), .TURN_CYCLES(6), .ARRIVE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .halt(halt), .ls(ls), .rs(rs),
        .lb(lb), .rb(rb), .fb(fb), .bb(bb),
        .lwa(lwa), .rwa(rwa), .state(state), .busy(busy), .arrived(arrived)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] model(input logic [2:0] l, input logic [2:0] r, input logic [2:0] st);
        logic b, a;
        b = (st == 3'd1) || (st == 3'd2) || (st == 3'd3);
        a = (st == 3'd4);
        return {l, r, st, b, a};
    endfunction

    // Packed as {lwa, rwa, state, busy, arrived}.
    task automatic compare(input string nm, input logic [10:0] exp_v);
        logic [10:0] act;
        act = {lwa, rwa, state, busy, arrived};
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %03b/%03b st=%0d busy=%b arr=%b, want %03b/%03b st=%0d busy=%b arr=%b",
                     nm, cyc, act[10:8], act[7:5], act[4:2], act[1], act[0],
                     exp_v[10:8], exp_v[7:5], exp_v[4:2], exp_v[1], exp_v[0]);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                if (e.cyc < cyc) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL %s: expectation for cyc %0d missed, now cyc %0d", e.name, e.cyc, cyc);
                end else begin
                    compare(e.name, e.v);
                end
            end
        end
    end

    task automatic tick(input string nm, input logic [2:0] l, input logic [2:0] r, input logic [2:0] st);
        exp_t e;
        e.cyc  = cyc + 1;
        e.name = nm;
        e.v    = model(l, r, st);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic ticks(input int n, input string nm, input logic [2:0] l, input logic [2:0] r, input logic [2:0] st);
        for (int i = 0; i < n; i++)
            tick(nm, l, r, st);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst_n = 1'b0; go = 1'b0; halt = 1'b0;
        ls = 3'd7; rs = 3'd7; lb = 1'b0; rb = 1'b0; fb = 1'b0; bb = 1'b0;
        repeat (2) @(negedge clk);
        compare("reset_hold", model(S, S, 3'd0));
        rst_n = 1'b1;
        tick("idle_go0", S, S, 3'd0);

        go = 1'b1; ls = 3'd2; rs = 3'd5;
        tick("start", S, F, 3'd1);
        tick("seek_left_strong", S, F, 3'd1);

        lb = 1'b1; tick("lb_enter", R, R, 3'd2); lb = 1'b0;
        ticks(7, "lb_backup", R, R, 3'd2);
        ticks(6, "lb_turn", F, R, 3'd3);
        tick("lb_reseek", S, F, 3'd1);

        bb = 1'b1; tick("bb_enter", F, F, 3'd2); bb = 1'b0;
        ticks(7, "bb_escape", F, F, 3'd2);
        ticks(6, "bb_turn", F, R, 3'd3);
        tick("bb_reseek", S, F, 3'd1);

        fb = 1'b1; tick("fb_enter", R, R, 3'd2); fb = 1'b0;
        ticks(2, "fb_backup", R, R, 3'd2);
        bb = 1'b1; tick("bb_abort", F, R, 3'd3); bb = 1'b0;
        ticks(5, "abort_turn", F, R, 3'd3);
        tick("abort_reseek", S, F, 3'd1);

        ls = 3'd5; rs = 3'd2;
        tick("right_strong", F, S, 3'd1);
        rb = 1'b1; tick("rb_enter", R, R, 3'd2); rb = 1'b0;
        ticks(7, "rb_backup", R, R, 3'd2);
        ticks(4, "rb_turn", R, F, 3'd3);
        halt = 1'b1; tick("halt_turn", S, S, 3'd0);
        tick("halt_beats_go", S, S, 3'd0);
        halt = 1'b0;

        ls = 3'd7; rs = 3'd7; tick("lost_beacon", F, R, 3'd1);
        ls = 3'd3; rs = 3'd3; tick("equal_mid", F, F, 3'd1);

        ls = 3'd0; rs = 3'd0;
        ticks(3, "pre_arrive", F, F, 3'd1);
        fb = 1'b1; tick("bump_beats_arrive", R, R, 3'd2); fb = 1'b0;
        halt = 1'b1; tick("halt_backup", S, S, 3'd0); halt = 1'b0;

        tick("arr_enter", F, F, 3'd1);
        ticks(2, "arr_count", F, F, 3'd1);
        ls = 3'd1; tick("arr_break", F, S, 3'd1);
        ls = 3'd0;
        ticks(3, "arr_recount", F, F, 3'd1);
        tick("arrive", S, S, 3'd4);
        tick("done_hold", S, S, 3'd4);
        go = 1'b0; tick("done_exit", S, S, 3'd0);

        go = 1'b1; ls = 3'd3; rs = 3'd3;
        tick("pre_rst", F, F, 3'd1);
        lb = 1'b1; tick("rst_bk_enter", R, R, 3'd2); lb = 1'b0;
        tick("rst_bk", R, R, 3'd2);
        #2 rst_n = 1'b0;
        #1 compare("async_rst", model(S, S, 3'd0));
        @(negedge clk);
        go = 1'b0; rst_n = 1'b1;
        tick("after_rst", S, S, 3'd0);

        repeat (2) @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: %0d expectations left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/renee_nav_ctrl.md
# renee_nav_ctrl

Sequential navigation controller for the Renee robot: drives the left and right wheel actions from the 3-bit beacon sensors and the four bumpers. Beacon-following steering becomes a timed obstacle-escape sequence (back up, then turn away) and a debounced arrival detector, and everything sits under a start/halt handshake. It sits between the sensor/bumper inputs and the wheel drivers, and is the top-level sequencer of the robot datapath.

## Interface
- `BACK_CYCLES`, default 8: cycles spent reversing (or escaping forward) after a bump; range 1..255.
- `TURN_CYCLES`, default 6: cycles spent pivoting after the back-up phase; range 1..255.
- `ARRIVE_CYCLES`, default 4: consecutive strongest-signal cycles required to declare arrival; range 1..255.
- `clk  in  1`: single clock; all state changes on its rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `go  in  1`: start request; level-sensitive.
- `halt  in  1`: synchronous stop; highest priority after reset.
- `ls, rs  in  3 each`: left and right beacon strength; 000 is strongest, 111 is weakest/none.
- `lb, rb, fb, bb  in  1 each`: left, right, front and back bumpers; active-high.
- `lwa, rwa  out  3 each`: registered one-hot wheel actions: 100 = F (forward), 010 = R (reverse), 001 = S (stop).
- `state  out  3`: current FSM state encoding, for debug.
- `busy  out  1`: high in SEEK, BACKUP or TURN.
- `arrived  out  1`: high in DONE.

## Operation
- States: IDLE, SEEK, BACKUP, TURN, DONE.
- **IDLE**
  - Outputs S/S.
  - `go` moves the FSM to SEEK.
- **SEEK**, in priority order:
  - **Bump.** If any bumper is high, move to BACKUP.
    - Latch `lb`, `rb`, `fb`, `bb` into `bump_q`.
    - Load the timer with `BACK_CYCLES`-1.
  - **Arrival.** If `ls`=`rs`=000 for `ARRIVE_CYCLES` consecutive SEEK cycles, move to DONE.
  - **Steering:**
    - `ls`<`rs` (left stronger): S/F.
    - `ls`>`rs`: F/S.
    - `ls`==`rs`!=111: F/F.
    - `ls`==`rs`==111 (beacon lost): search pivot F/R.
- **BACKUP**
  - Outputs R/R, except when `bump_q.bb`=1: F/F (escape forward).
  - A new rising `bb` during a reverse BACKUP aborts it: go to TURN next cycle.
  - `lb`, `rb` and `fb` are ignored in BACKUP.
  - When the timer reaches 0, go to TURN and load the timer with `TURN_CYCLES`-1.
- **TURN**
  - `bump_q` left-only: pivot right, F/R.
  - `bump_q` right-only: pivot left, R/F.
  - Any other combination: pivot right, F/R.
  - All bumpers are ignored in TURN.
  - When the timer reaches 0, return to SEEK and clear `bump_q` and the arrival counter.
- **DONE**
  - Outputs S/S; `arrived`=1.
  - Return to IDLE when `go`=0.
- **halt=1** in any state: IDLE next edge, outputs S/S, timer and arrival counter cleared.
- **Reset:**
  - State IDLE.
  - `lwa`=`rwa`=001.
  - `busy`=0, `arrived`=0.
  - `bump_q`=0.
  - Timer and arrival counter at 0.
- **Counters:**
  - Timer is an 8-bit down-counter that saturates at 0.
  - Arrival counter is 8-bit, saturating at `ARRIVE_CYCLES`.
  - The arrival counter resets on any non-000/000 sample and on leaving SEEK.

## Timing
- Inputs are sampled at the rising edge. State and `lwa`/`rwa` update at that same edge, so there is one cycle of latency from input to wheel action.
- BACKUP presents its output for exactly `BACK_CYCLES` cycles; TURN for exactly `TURN_CYCLES` cycles, unless aborted by `halt` or by the `bb` abort.
- A bumper still high on SEEK re-entry triggers BACKUP on the first SEEK sample, so SEEK lasts one cycle.
- Bump and arrival in the same SEEK cycle: bump wins.
- `go` and `halt` both high: `halt` wins; the FSM stays in IDLE.
- Reset asserted mid-sequence: outputs are forced to S/S immediately (asynchronously), with no wait for a clock edge.

## Structure
- Shared package `renee_pkg` holds:
  - Wheel-action constants `WA_F`=3'b100, `WA_R`=3'b010, `WA_S`=3'b001.
  - FSM state encodings: IDLE=0, SEEK=1, BACKUP=2, TURN=3, DONE=4.
- Sub-module `renee_steer`: combinational beacon steering. Takes `ls`, `rs`; produces the SEEK-state `lwa`/`rwa` and a `strongest` flag, using an unsigned 3-bit compare.
- The top level holds the FSM, timer, arrival counter and `bump_q`.

## Test plan
- **Reset and start.** Reset; release with `go`=0 → `lwa`=`rwa`=001, `state`=0. Raise `go`, `ls`=010, `rs`=101 → next edge `lwa`=001, `rwa`=100, `busy`=1.
- **Left bump.** Left bump in SEEK with defaults → exactly 8 cycles of 010/010, then 6 cycles of 100/010, then SEEK.
- **Back bump.** `bb` bump → 8 cycles of 100/100, then 6 cycles of 100/010 (right pivot). Separately: `fb` bump, then `bb` pulsed in the 3rd BACKUP cycle → TURN begins the next cycle.
- **Arrival.** `ls`=`rs`=000 held for 4 SEEK cycles → DONE, `arrived`=1, outputs 001/001. A single non-zero sample in between restarts the count. Drop `go` → IDLE.
- **Lost beacon.** `ls`=`rs`=111 in SEEK → 100/010. `ls`=`rs`=011 → 100/100.
- **Halt and reset.** `halt` in the 4th TURN cycle → IDLE, 001/001 next edge. Async `rst_n` low mid-BACKUP → outputs 001/001 immediately, `state`=0.
